uart_cmd_parser: RTL and testbench

Byte-level command decoder between the UART receiver and the clock/alarm datapath. Consumes received bytes, assembles fixed-length framed commands, validates header, checksum, command code and time ranges, then updates the registered mode, adjust and alarm parameters. These parameters feed `digital_clock` and `alarm_settings`. Malformed or stalled frames are discarded without disturbing any held parameter.

---
 rtl/uart_cmd_parser.sv | 125 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 6-byte framed commands from UART bytes and updates registered clock/alarm parameters.
// Frame: HEADER, CMD, B0, B1, B2, CHK with CHK = CMD ^ B0 ^ B1 ^ B2.
module uart_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 270000,
    parameter logic [7:0]  HEADER         = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [2:0] mode,
    output logic [1:0] adjust_mode,
    output logic [1:0] adjust_way,
    output logic [5:0] adjust_hour,
    output logic [5:0] adjust_minute,
    output logic [5:0] adjust_second,
    output logic [5:0] alarm1_hour,
    output logic [5:0] alarm1_minute,
    output logic [5:0] alarm1_second,
    output logic [5:0] alarm2_hour,
    output logic [5:0] alarm2_minute,
    output logic [5:0] alarm2_second,
    output logic [5:0] alarm3_hour,
    output logic [5:0] alarm3_minute,
    output logic [5:0] alarm3_second,
    output logic       cmd_ok,
    output logic       cmd_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_P0, S_P1, S_P2, S_CHK} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0] r_cmd, r_b0, r_b1, r_b2, r_xor;
    logic [2:0] r_mode;
    logic [1:0] r_adj_mode, r_adj_way;
    logic [17:0] r_adj, r_al1, r_al2, r_al3;
    logic r_ok, r_err;
    logic w_timeout, w_chk, w_time_ok, w_dis, w_range, w_accept, w_reject;

    assign w_timeout = r_state != S_IDLE && !rx_valid && r_cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = w_timeout ? S_IDLE :
                 !rx_valid ? r_state :
                 r_state == S_IDLE ? (rx_data == HEADER ? S_CMD : S_IDLE) :
                 r_state == S_CHK ? S_IDLE : state_t'(r_state + 3'd1);
    end

    // Validation of the completed frame; the CHK byte itself is compared combinationally.
    always_comb begin
        w_chk     = r_state == S_CHK && rx_valid;
        w_time_ok = r_b0 <= 8'd23 && r_b1 <= 8'd59 && r_b2 <= 8'd59;
        w_dis     = r_b0 == 8'h3F && r_b1 == 8'h3F && r_b2 == 8'h3F;
        w_range   = r_cmd == 8'd1 ? w_time_ok :
                    r_cmd == 8'd2 ? (r_b0 >= 8'd1 && r_b0 <= 8'd3 && r_b1 >= 8'd1 && r_b1 <= 8'd2) :
                    r_cmd >= 8'd5 ? (w_time_ok || w_dis) : 1'b1;
        w_accept  = w_chk && rx_data == r_xor && r_cmd <= 8'h07 && w_range;
        w_reject  = (w_chk && !w_accept) || w_timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_cmd <= '0;
            r_b0  <= '0;
            r_b1  <= '0;
            r_b2  <= '0;
            r_xor <= '0;
        end else begin
            r_cnt <= (r_state == S_IDLE || rx_valid) ? '0 : r_cnt + CW'(1);
            if (rx_valid) begin
                if (r_state == S_CMD) r_cmd <= rx_data;
                if (r_state == S_P0)  r_b0  <= rx_data;
                if (r_state == S_P1)  r_b1  <= rx_data;
                if (r_state == S_P2)  r_b2  <= rx_data;
                if (r_state == S_CMD) r_xor <= rx_data;
                else if (r_state == S_P0 || r_state == S_P1 || r_state == S_P2) r_xor <= r_xor ^ rx_data;
            end
        end
    end

    // Alarm registers reset to 63, a value no valid time can match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= '0;
            r_adj_mode <= '0;
            r_adj_way  <= '0;
            r_adj      <= '0;
            r_al1      <= '1;
            r_al2      <= '1;
            r_al3      <= '1;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ok  <= w_accept;
            r_err <= w_reject;
            if (w_accept) begin
                r_mode <= r_cmd[2:0];
                if (r_cmd[2:0] == 3'd1) r_adj <= {r_b0[5:0], r_b1[5:0], r_b2[5:0]};
                if (r_cmd[2:0] == 3'd2) begin
                    r_adj_mode <= r_b0[1:0];
                    r_adj_way  <= r_b1[1:0];
                end
                if (r_cmd[2:0] == 3'd5) r_al1 <= {r_b0[5:0], r_b1[5:0], r_b2[5:0]};
                if (r_cmd[2:0] == 3'd6) r_al2 <= {r_b0[5:0], r_b1[5:0], r_b2[5:0]};
                if (r_cmd[2:0] == 3'd7) r_al3 <= {r_b0[5:0], r_b1[5:0], r_b2[5:0]};
            end
        end
    end

    assign mode        = r_mode;
    assign adjust_mode = r_adj_mode;
    assign adjust_way  = r_adj_way;
    assign {adjust_hour, adjust_minute, adjust_second} = r_adj;
    assign {alarm1_hour, alarm1_minute, alarm1_second} = r_al1;
    assign {alarm2_hour, alarm2_minute, alarm2_second} = r_al2;
    assign {alarm3_hour, alarm3_minute, alarm3_second} = r_al3;
    assign cmd_ok  = r_ok;
    assign cmd_err = r_err;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table-driven frame vectors plus directed timeout, back-to-back and reset sequences.
module tb_uart_cmd_parser;
    logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [2:0] mode;
    logic [1:0] adjust_mode, adjust_way;
    logic [5:0] adjust_hour, adjust_minute, adjust_second;
    logic [5:0] alarm1_hour, alarm1_minute, alarm1_second;
    logic [5:0] alarm2_hour, alarm2_minute, alarm2_second;
    logic [5:0] alarm3_hour, alarm3_minute, alarm3_second;
    logic cmd_ok, cmd_err;
    int n_vec = 0, n_mis = 0, n_ok = 0, n_errp = 0, ok0, err0;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYCLES(100), .HEADER(8'hAA)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mode(mode), .adjust_mode(adjust_mode), .adjust_way(adjust_way),
        .adjust_hour(adjust_hour), .adjust_minute(adjust_minute), .adjust_second(adjust_second),
        .alarm1_hour(alarm1_hour), .alarm1_minute(alarm1_minute), .alarm1_second(alarm1_second),
        .alarm2_hour(alarm2_hour), .alarm2_minute(alarm2_minute), .alarm2_second(alarm2_second),
        .alarm3_hour(alarm3_hour), .alarm3_minute(alarm3_minute), .alarm3_second(alarm3_second),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err)
    );

    always @(posedge clk) begin
        n_ok   <= n_ok + int'(cmd_ok);
        n_errp <= n_errp + int'(cmd_err);
    end

    typedef struct {
        logic [63:0] b;
        int          len;
        logic        ok;
        logic        err;
        logic [2:0]  mode;
        logic [17:0] adj;
        logic [1:0]  am;
        logic [1:0]  aw;
        logic [17:0] a1;
        logic [17:0] a2;
        logic [17:0] a3;
    } vec_t;

    localparam logic [17:0] OFF = 18'h3FFFF;
    vec_t tv [13];

    function automatic logic [17:0] t(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    function automatic vec_t mk(input int len, input logic [63:0] b, input logic ok, input logic err,
                                input logic [2:0] md, input logic [17:0] adj, input logic [1:0] am,
                                input logic [1:0] aw, input logic [17:0] a1, input logic [17:0] a2,
                                input logic [17:0] a3);
        vec_t v;
        v.len = len; v.b = b; v.ok = ok; v.err = err; v.mode = md; v.adj = adj;
        v.am = am; v.aw = aw; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [2:0] md, input logic [17:0] adj, input logic [1:0] am,
                            input logic [1:0] aw, input logic [17:0] a1, input logic [17:0] a2, input logic [17:0] a3);
        chk({nm, ".mode"}, 32'(mode), 32'(md));
        chk({nm, ".adj"}, 32'({adjust_hour, adjust_minute, adjust_second}), 32'(adj));
        chk({nm, ".adj_mode"}, 32'(adjust_mode), 32'(am));
        chk({nm, ".adj_way"}, 32'(adjust_way), 32'(aw));
        chk({nm, ".alarm1"}, 32'({alarm1_hour, alarm1_minute, alarm1_second}), 32'(a1));
        chk({nm, ".alarm2"}, 32'({alarm2_hour, alarm2_minute, alarm2_second}), 32'(a2));
        chk({nm, ".alarm3"}, 32'({alarm3_hour, alarm3_minute, alarm3_second}), 32'(a3));
    endtask

    task automatic send(input logic [7:0] x);
        rx_data = x;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [63:0] b, input int len);
        for (int i = 0; i < len; i++) send(b[8*(len-1-i) +: 8]);
    endtask

    initial begin
        tv[0]  = mk(6, 64'hAA010C1E2D3E,      1, 0, 1, t(12,30,45), 0, 0, OFF,        OFF, OFF);
        tv[1]  = mk(6, 64'hAA051800001D,      0, 1, 1, t(12,30,45), 0, 0, OFF,        OFF, OFF);
        tv[2]  = mk(6, 64'hAA05173B3B12,      1, 0, 5, t(12,30,45), 0, 0, t(23,59,59), OFF, OFF);
        tv[3]  = mk(6, 64'hAA0203020003,      1, 0, 2, t(12,30,45), 3, 2, t(23,59,59), OFF, OFF);
        tv[4]  = mk(6, 64'hAA0203020004,      0, 1, 2, t(12,30,45), 3, 2, t(23,59,59), OFF, OFF);
        tv[5]  = mk(8, 64'h5511AA0400000004,  1, 0, 4, t(12,30,45), 3, 2, t(23,59,59), OFF, OFF);
        tv[6]  = mk(6, 64'hAA0800000008,      0, 1, 4, t(12,30,45), 3, 2, t(23,59,59), OFF, OFF);
        tv[7]  = mk(6, 64'hAA0200010003,      0, 1, 4, t(12,30,45), 3, 2, t(23,59,59), OFF, OFF);
        tv[8]  = mk(6, 64'hAA07003B003C,      1, 0, 7, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));
        tv[9]  = mk(6, 64'hAA06003C003A,      0, 1, 7, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));
        tv[10] = mk(6, 64'hAA063F000039,      0, 1, 7, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));
        tv[11] = mk(6, 64'hAA0300000003,      1, 0, 3, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));
        tv[12] = mk(6, 64'hAA01AA0000AB,      0, 1, 3, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));

        repeat (2) @(negedge clk);
        chk("reset.cmd_ok", 32'(cmd_ok), 0);
        chk("reset.cmd_err", 32'(cmd_err), 0);
        chk_outs("reset", 0, 0, 0, 0, OFF, OFF, OFF);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            ok0 = n_ok; err0 = n_errp;
            run_frame(tv[i].b, tv[i].len);
            chk($sformatf("v%0d.cmd_ok", i), 32'(cmd_ok), 32'(tv[i].ok));
            chk($sformatf("v%0d.cmd_err", i), 32'(cmd_err), 32'(tv[i].err));
            @(negedge clk);
            chk($sformatf("v%0d.ok_pulses", i), 32'(n_ok - ok0), 32'(tv[i].ok));
            chk($sformatf("v%0d.err_pulses", i), 32'(n_errp - err0), 32'(tv[i].err));
            chk_outs($sformatf("v%0d", i), tv[i].mode, tv[i].adj, tv[i].am, tv[i].aw, tv[i].a1, tv[i].a2, tv[i].a3);
        end

        // Timeout: header + cmd, then silence; trailing bytes must be dropped in IDLE.
        ok0 = n_ok; err0 = n_errp;
        run_frame(64'hAA01, 2);
        repeat (99) @(negedge clk);
        chk("to.early_err", 32'(cmd_err), 0);
        @(negedge clk);
        chk("to.cmd_err", 32'(cmd_err), 1);
        run_frame(64'h0C1E2D3E, 4);
        repeat (2) @(negedge clk);
        chk("to.ok_pulses", 32'(n_ok - ok0), 0);
        chk("to.err_pulses", 32'(n_errp - err0), 1);
        chk_outs("to", 3, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));

        // Byte landing on the expiry cycle wins.
        ok0 = n_ok; err0 = n_errp;
        run_frame(64'hAA01, 2);
        repeat (99) @(negedge clk);
        run_frame(64'h0C1E2D3E, 4);
        chk("edge.cmd_ok", 32'(cmd_ok), 1);
        @(negedge clk);
        chk("edge.ok_pulses", 32'(n_ok - ok0), 1);
        chk("edge.err_pulses", 32'(n_errp - err0), 0);
        chk_outs("edge", 1, t(12,30,45), 3, 2, t(23,59,59), OFF, t(0,59,0));

        // Back-to-back frames with no idle cycle between them.
        ok0 = n_ok;
        run_frame(64'hAA0400000004, 6);
        chk("b2b.first_ok", 32'(cmd_ok), 1);
        chk("b2b.first_mode", 32'(mode), 4);
        run_frame(64'hAA0300000003, 6);
        chk("b2b.second_ok", 32'(cmd_ok), 1);
        @(negedge clk);
        chk("b2b.ok_pulses", 32'(n_ok - ok0), 2);
        chk("b2b.mode", 32'(mode), 3);

        // Reset mid-frame clears outputs asynchronously and discards the partial frame.
        run_frame(64'hAA0601, 3);
        rst = 1'b1;
        #1;
        chk_outs("rst_async", 0, 0, 0, 0, OFF, OFF, OFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok0 = n_ok;
        run_frame(64'h020304, 3);
        repeat (2) @(negedge clk);
        chk("rst.ok_pulses", 32'(n_ok - ok0), 0);
        chk_outs("rst", 0, 0, 0, 0, OFF, OFF, OFF);
        run_frame(64'hAA063F3F3F39, 6);
        chk("dis.cmd_ok", 32'(cmd_ok), 1);
        @(negedge clk);
        chk_outs("dis", 6, 0, 0, 0, OFF, OFF, OFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
